// File: rtl/seq_addsub_p_if.sv
// Operand/result bundle for the chunked adder/subtractor.
// The master drives the operands and start; the slave returns the status and result.
interface seq_addsub_p_if #(
    parameter int SIZE = 32
);
    logic            start;
    logic            sub;
    logic [SIZE-1:0] A;
    logic [SIZE-1:0] B;
    logic            cin;
    logic            busy;
    logic            done;
    logic [SIZE-1:0] SUM;
    logic            cout;
    logic            ovf;

    modport master (
        output start, sub, A, B, cin,
        input  busy, done, SUM, cout, ovf
    );

    modport slave (
        input  start, sub, A, B, cin,
        output busy, done, SUM, cout, ovf
    );
endinterface

// File: rtl/seq_addsub_p.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock, LSB chunk first, with a registered carry.
// state | meaning: S_IDLE wait for start; S_RUN add chunk k; S_DONE one-cycle done, may re-accept.
module seq_addsub_p #(
    parameter int SIZE  = 32,
    parameter int CHUNK = 8
) (
    input  logic          clk,
    input  logic          rst,
    seq_addsub_p_if.slave bus
);
    localparam int NCH = SIZE / CHUNK;
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NCH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state_q;
    logic [SIZE-1:0] a_q;
    logic [SIZE-1:0] b_q;
    logic [SIZE-1:0] sum_q;
    logic [KW-1:0]   k_q;
    logic            carry_q;
    logic            cout_q;
    logic            ovf_q;
    logic            busy_q;
    logic            done_q;

    logic [CHUNK-1:0] a_ch;
    logic [CHUNK-1:0] b_ch;
    logic [CHUNK:0]   ch_sum;
    logic             msb_cin;

    always_comb begin
        a_ch    = a_q[int'(k_q) * CHUNK +: CHUNK];
        b_ch    = b_q[int'(k_q) * CHUNK +: CHUNK];
        ch_sum  = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry_q};
        // Only meaningful on the last chunk: carry entering the result MSB.
        msb_cin = a_ch[CHUNK-1] ^ b_ch[CHUNK-1] ^ ch_sum[CHUNK-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            k_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        a_q     <= bus.A;
                        b_q     <= bus.B ^ {SIZE{bus.sub}};
                        carry_q <= bus.sub | bus.cin;
                        k_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    sum_q[int'(k_q) * CHUNK +: CHUNK] <= ch_sum[CHUNK-1:0];
                    carry_q <= ch_sum[CHUNK];
                    if (k_q == K_LAST) begin
                        cout_q  <= ch_sum[CHUNK];
                        ovf_q   <= msb_cin ^ ch_sum[CHUNK];
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        k_q <= k_q + KW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.SUM  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_seq_addsub_p.sv
// Bench for seq_addsub_p: a 32/8 instance and a 16/16 instance checked against an A+/-B model.
module tb_seq_addsub_p;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    seq_addsub_p_if #(.SIZE(32)) bw ();
    seq_addsub_p_if #(.SIZE(16)) bn ();

    seq_addsub_p #(.SIZE(32), .CHUNK(8))  dut_w (.clk(clk), .rst(rst), .bus(bw.slave));
    seq_addsub_p #(.SIZE(16), .CHUNK(16)) dut_n (.clk(clk), .rst(rst), .bus(bn.slave));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain modular arithmetic on n-bit two's complement values.
    function automatic logic [65:0] model(input int n, input logic [63:0] a, input logic [63:0] b,
                                          input logic s, input logic c);
        logic [63:0] mask;
        logic [63:0] aa;
        logic [63:0] bb;
        logic [63:0] full;
        logic [63:0] sm;
        logic        co;
        logic        ov;
        mask = (64'd1 << n) - 64'd1;
        aa   = a & mask;
        bb   = s ? (~b & mask) : (b & mask);
        full = aa + bb + {63'd0, (s ? 1'b1 : c)};
        sm   = full & mask;
        co   = full[n];
        ov   = (aa[n-1] == bb[n-1]) && (sm[n-1] != aa[n-1]);
        return {ov, co, sm};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit nar, input logic st, input logic s, input logic [63:0] a,
                         input logic [63:0] b, input logic c);
        if (nar) begin
            bn.start = st; bn.sub = s; bn.A = a[15:0]; bn.B = b[15:0]; bn.cin = c;
        end else begin
            bw.start = st; bw.sub = s; bw.A = a[31:0]; bw.B = b[31:0]; bw.cin = c;
        end
    endtask

    function automatic logic get_done(input bit nar);
        return nar ? bn.done : bw.done;
    endfunction

    function automatic logic get_busy(input bit nar);
        return nar ? bn.busy : bw.busy;
    endfunction

    function automatic logic [65:0] get_res(input bit nar);
        return nar ? {bn.ovf, bn.cout, 48'd0, bn.SUM} : {bw.ovf, bw.cout, 32'd0, bw.SUM};
    endfunction

    task automatic check_res(input string tag, input bit nar, input logic [65:0] exp);
        logic [65:0] r;
        r = get_res(nar);
        chk({tag, "_sum"},  r[63:0],      exp[63:0]);
        chk({tag, "_cout"}, {63'd0, r[64]}, {63'd0, exp[64]});
        chk({tag, "_ovf"},  {63'd0, r[65]}, {63'd0, exp[65]});
    endtask

    task automatic run_op(input string tag, input bit nar, input logic s, input logic [63:0] a,
                          input logic [63:0] b, input logic c);
        int          nch;
        int          lat;
        int          nbusy;
        logic [65:0] exp;
        nch = nar ? 1 : 4;
        exp = model(nar ? 16 : 32, a, b, s, c);
        drive(nar, 1'b1, s, a, b, c);
        tick();
        drive(nar, 1'b0, s, a, b, c);
        lat   = 0;
        nbusy = 0;
        while (get_done(nar) !== 1'b1 && lat < 20) begin
            if (get_busy(nar) === 1'b1) nbusy++;
            tick();
            lat++;
        end
        chk({tag, "_lat"},  64'(lat),   64'(nch));
        chk({tag, "_busy"}, 64'(nbusy), 64'(nch));
        chk({tag, "_busy_at_done"}, {63'd0, get_busy(nar)}, 64'd0);
        check_res(tag, nar, exp);
        tick();
        chk({tag, "_done_pulse"}, {63'd0, get_done(nar)}, 64'd0);
    endtask

    initial begin
        int          lat;
        int          ndone;
        logic [65:0] e1;
        logic [65:0] e2;
        logic [31:0] ra;
        logic [31:0] rb;

        drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
        #2 rst = 1'b1;
        tick();
        tick();
        chk("rst_busy", {63'd0, bw.busy}, 64'd0);
        chk("rst_done", {63'd0, bw.done}, 64'd0);
        check_res("rst_w", 1'b0, 66'd0);
        check_res("rst_n", 1'b1, 66'd0);
        #2 rst = 1'b0;
        tick();

        run_op("ffff_plus_1", 1'b0, 1'b0, 64'hFFFF_FFFF, 64'h1, 1'b0);
        run_op("max_pos_plus_1", 1'b0, 1'b0, 64'h7FFF_FFFF, 64'h1, 1'b0);
        run_op("5_minus_7", 1'b0, 1'b1, 64'd5, 64'd7, 1'b0);
        run_op("7_minus_5", 1'b0, 1'b1, 64'd7, 64'd5, 1'b1);

        // start pulsed again during the third busy cycle must be ignored
        e1 = model(32, 64'h1234_5678, 64'h0F0F_0F0F, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 64'h1234_5678, 64'h0F0F_0F0F, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 64'h1234_5678, 64'h0F0F_0F0F, 1'b1);
        tick();
        tick();
        drive(1'b0, 1'b1, 1'b1, 64'hDEAD_BEEF, 64'h0BAD_F00D, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b1, 64'hDEAD_BEEF, 64'h0BAD_F00D, 1'b0);
        lat = 3;
        while (bw.done !== 1'b1 && lat < 20) begin tick(); lat++; end
        chk("midstart_lat", 64'(lat), 64'd4);
        check_res("midstart", 1'b0, e1);
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bw.done === 1'b1) ndone++;
        end
        chk("midstart_single_done", 64'(ndone), 64'd0);

        // start held through DONE: second op accepted on the done cycle
        e1 = model(32, 64'hAAAA_5555, 64'h1234_5678, 1'b1, 1'b0);
        e2 = model(32, 64'h00FF_00FF, 64'hFF00_FF00, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 64'hAAAA_5555, 64'h1234_5678, 1'b0);
        tick();
        drive(1'b0, 1'b1, 1'b0, 64'h00FF_00FF, 64'hFF00_FF00, 1'b1);
        lat = 0;
        while (bw.done !== 1'b1 && lat < 20) begin tick(); lat++; end
        chk("b2b_first_lat", 64'(lat), 64'd4);
        check_res("b2b_first", 1'b0, e1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 64'h00FF_00FF, 64'hFF00_FF00, 1'b1);
        lat = 1;
        while (bw.done !== 1'b1 && lat < 20) begin tick(); lat++; end
        chk("b2b_done_gap", 64'(lat), 64'd5);
        check_res("b2b_second", 1'b0, e2);
        tick();

        // reset during the second RUN cycle aborts at once
        drive(1'b0, 1'b1, 1'b0, 64'h1111_11FF, 64'h2222_2201, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 64'h1111_11FF, 64'h2222_2201, 1'b1);
        tick();
        chk("pre_rst_busy", {63'd0, bw.busy}, 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", {63'd0, bw.busy}, 64'd0);
        chk("abort_done", {63'd0, bw.done}, 64'd0);
        check_res("abort", 1'b0, 66'd0);
        #2 rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bw.done === 1'b1) ndone++;
        end
        chk("abort_no_done", 64'(ndone), 64'd0);
        run_op("3_plus_4_cin", 1'b0, 1'b0, 64'd3, 64'd4, 1'b1);

        run_op("n16_8000_8000", 1'b1, 1'b0, 64'h8000, 64'h8000, 1'b0);
        run_op("n16_0_minus_1", 1'b1, 1'b1, 64'h0, 64'h1, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 16 == 0) ra = 32'h8000_0000;
            if (i % 16 == 1) rb = 32'hFFFF_FFFF;
            run_op("rand_w", 1'b0, 1'($urandom_range(0, 1)), {32'd0, ra}, {32'd0, rb},
                   1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 200; i++) begin
            run_op("rand_n", 1'b1, 1'($urandom_range(0, 1)), 64'($urandom_range(0, 65535)),
                   64'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
